// File: rtl/vga_timing_pkg.sv
// Timing constants and pixel types for the 640x480@60 Hz VGA path.
// Also holds the RGB565 colours shared with the pattern generator.
package vga_timing_pkg;

  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_BACK   = 10'd48;
  localparam logic [9:0] H_VALID  = 10'd640;
  localparam logic [9:0] H_FRONT  = 10'd16;
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BACK   = 10'd33;
  localparam logic [9:0] V_VALID  = 10'd480;
  localparam logic [9:0] V_FRONT  = 10'd10;
  localparam logic       SYNC_POL = 1'b0;

  localparam int H_TOTAL = int'(H_SYNC) + int'(H_BACK) + int'(H_VALID) + int'(H_FRONT);
  localparam int V_TOTAL = int'(V_SYNC) + int'(V_BACK) + int'(V_VALID) + int'(V_FRONT);
  localparam logic [9:0] H_START = H_SYNC + H_BACK;
  localparam logic [9:0] V_START = V_SYNC + V_BACK;

  typedef logic [15:0] pixel_t;

  localparam pixel_t RGB_BLACK = 16'h0000;
  localparam pixel_t RGB_WHITE = 16'hFFFF;
  localparam pixel_t RGB_RED   = 16'hF800;
  localparam pixel_t RGB_GREEN = 16'h07E0;
  localparam pixel_t RGB_BLUE  = 16'h001F;

endpackage

// File: rtl/vga_wrap_cnt.sv
// Enabled up-counter that wraps MAX -> 0; wrap flags the enabled cycle at MAX.
module vga_wrap_cnt #(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             vga_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == MAX) ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = en && (cnt_q == MAX);

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator: sync pulses, pixel coordinate requests one clock ahead
// of active video, and gating of the returned pixel data onto the RGB pins.
module vga_ctrl #(
  parameter logic [9:0] H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter logic [9:0] H_BACK   = vga_timing_pkg::H_BACK,
  parameter logic [9:0] H_VALID  = vga_timing_pkg::H_VALID,
  parameter logic [9:0] H_FRONT  = vga_timing_pkg::H_FRONT,
  parameter logic [9:0] V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter logic [9:0] V_BACK   = vga_timing_pkg::V_BACK,
  parameter logic [9:0] V_VALID  = vga_timing_pkg::V_VALID,
  parameter logic [9:0] V_FRONT  = vga_timing_pkg::V_FRONT,
  parameter logic       SYNC_POL = vga_timing_pkg::SYNC_POL
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        rgb_valid,
  output logic        frame_start
);

  import vga_timing_pkg::*;

  localparam int H_TOT = int'(H_SYNC) + int'(H_BACK) + int'(H_VALID) + int'(H_FRONT);
  localparam int V_TOT = int'(V_SYNC) + int'(V_BACK) + int'(V_VALID) + int'(V_FRONT);

  localparam logic [9:0] H_MAX = 10'(H_TOT - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOT - 1);
  localparam logic [9:0] H_ST  = H_SYNC + H_BACK;
  localparam logic [9:0] V_ST  = V_SYNC + V_BACK;
  localparam logic [9:0] H_END = H_ST + H_VALID;
  localparam logic [9:0] V_END = V_ST + V_VALID;
  // Request window opens one clock early to cover the generator's register stage.
  localparam logic [9:0] H_REQ_ST  = H_ST - 10'd1;
  localparam logic [9:0] H_REQ_END = H_END - 10'd1;

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_totals
    $error("vga_ctrl: line or frame total exceeds the 10-bit counters");
  end

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       h_wrap;
  logic       v_wrap_unused;

  vga_wrap_cnt #(.WIDTH(10), .MAX(H_MAX)) u_cnt_h (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .en        (1'b1),
    .cnt       (cnt_h),
    .wrap      (h_wrap)
  );

  vga_wrap_cnt #(.WIDTH(10), .MAX(V_MAX)) u_cnt_v (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .en        (h_wrap),
    .cnt       (cnt_v),
    .wrap      (v_wrap_unused)
  );

  logic   h_act;
  logic   v_act;
  logic   h_req;
  logic   pix_req;
  pixel_t rgb_d;

  always_comb begin
    h_act   = (cnt_h >= H_ST) && (cnt_h < H_END);
    v_act   = (cnt_v >= V_ST) && (cnt_v < V_END);
    h_req   = (cnt_h >= H_REQ_ST) && (cnt_h < H_REQ_END);
    pix_req = h_req && v_act;
    rgb_d   = (h_act && v_act) ? pix_data : RGB_BLACK;
  end

  assign hsync       = (cnt_h < H_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign vsync       = (cnt_v < V_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign rgb_valid   = h_act && v_act;
  assign rgb         = rgb_d;
  assign pix_x       = pix_req ? (cnt_h - H_REQ_ST) : 10'h3FF;
  assign pix_y       = pix_req ? (cnt_v - V_ST) : 10'h3FF;
  assign frame_start = (cnt_h == 10'd0) && (cnt_v == 10'd0);

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed bench for vga_ctrl: a full-size 640x480 instance (A) and a
// reduced-geometry instance (B, 17 clks x 9 lines) for whole-frame behaviour.
module tb_vga_ctrl;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic        rst_a_n, rst_b_n;
  logic [15:0] pix_data_a, pix_data_b;
  logic [9:0]  px_a, py_a, px_b, py_b;
  logic        hs_a, vs_a, val_a, fs_a, hs_b, vs_b, val_b, fs_b;
  logic [15:0] rgb_a, rgb_b;

  vga_ctrl dut_a (
    .vga_clk(vga_clk), .sys_rst_n(rst_a_n), .pix_data(pix_data_a),
    .pix_x(px_a), .pix_y(py_a), .hsync(hs_a), .vsync(vs_a),
    .rgb(rgb_a), .rgb_valid(val_a), .frame_start(fs_a)
  );

  // B: H 4/3/8/2 (start 7, total 17), V 2/2/3/2 (start 4, total 9), frame 153 clks
  vga_ctrl #(
    .H_SYNC(10'd4), .H_BACK(10'd3), .H_VALID(10'd8), .H_FRONT(10'd2),
    .V_SYNC(10'd2), .V_BACK(10'd2), .V_VALID(10'd3), .V_FRONT(10'd2),
    .SYNC_POL(1'b0)
  ) dut_b (
    .vga_clk(vga_clk), .sys_rst_n(rst_b_n), .pix_data(pix_data_b),
    .pix_x(px_b), .pix_y(py_b), .hsync(hs_b), .vsync(vs_b),
    .rgb(rgb_b), .rgb_valid(val_b), .frame_start(fs_b)
  );

  // Model pixel generator for A: registers {6'h0, pix_x}
  always @(posedge vga_clk) pix_data_a <= {6'h0, px_a};
  assign pix_data_b = 16'hFFFF;

  int ncyc, ncyc_a;
  always @(posedge vga_clk or negedge rst_b_n)
    if (!rst_b_n) ncyc <= 0; else ncyc <= ncyc + 1;
  always @(posedge vga_clk or negedge rst_a_n)
    if (!rst_a_n) ncyc_a <= 0; else ncyc_a <= ncyc_a + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_n(input bit use_a, input int target);
    int g = 0;
    @(negedge vga_clk);
    while ((use_a ? ncyc_a : ncyc) != target && g < 40000) begin
      @(negedge vga_clk);
      g++;
    end
    chk($sformatf("reach_n%0d", target), use_a ? ncyc_a : ncyc, target);
  endtask

  // Whole-run monitors, windowed on the shared post-release cycle count
  int hs_low_a = 0, hs_low_a0 = 0, vs_low_a = 0, rgb_nz_a = 0, valid_a35 = 0, fs_extra_a = 0;
  int hs_low_b = 0, vs_low_b = 0, ff_b = 0, valid_b = 0, nfs_b = 0;
  int fs_pos_b[4];

  always @(negedge vga_clk) begin
    if (rst_a_n && rst_b_n && ncyc < 28800) begin
      if (ncyc < 800 && !hs_a) hs_low_a0++;
      if (ncyc < 28000) begin
        if (!hs_a) hs_low_a++;
        if (!vs_a) vs_low_a++;
        if (rgb_a != 16'h0) rgb_nz_a++;
      end else if (val_a) valid_a35++;
      if (ncyc > 0 && fs_a) fs_extra_a++;
    end
    if (rst_b_n && ncyc < 500) begin
      if (ncyc < 153) begin
        if (!hs_b) hs_low_b++;
        if (!vs_b) vs_low_b++;
        if (rgb_b == 16'hFFFF) ff_b++;
        if (val_b) valid_b++;
      end
      if (fs_b && nfs_b < 4) begin
        fs_pos_b[nfs_b] = ncyc;
        nfs_b++;
      end
    end
  end

  typedef struct {
    bit          sel;   // 0 = A, 1 = B
    int          n;
    logic        hs, vs, val;
    logic [9:0]  px, py;
    logic [15:0] rgb;
    logic        fs;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit sel, input int n, input logic hs, input logic vs,
                     input logic val, input logic [9:0] px, input logic [9:0] py,
                     input logic [15:0] rgb, input logic fs);
    vec_t v;
    v.sel = sel; v.n = n; v.hs = hs; v.vs = vs; v.val = val;
    v.px = px; v.py = py; v.rgb = rgb; v.fs = fs;
    vecs.push_back(v);
  endtask

  task automatic chk_a(input string tag, input logic hs, input logic vs, input logic val,
                       input logic [9:0] px, input logic [9:0] py, input logic [15:0] rgb,
                       input logic fs);
    chk({tag, ".hsync"}, hs_a, hs);
    chk({tag, ".vsync"}, vs_a, vs);
    chk({tag, ".rgb_valid"}, val_a, val);
    chk({tag, ".pix_x"}, px_a, px);
    chk({tag, ".pix_y"}, py_a, py);
    chk({tag, ".rgb"}, rgb_a, rgb);
    chk({tag, ".frame_start"}, fs_a, fs);
  endtask

  initial begin
    //  sel  n      hs   vs   val  pix_x    pix_y    rgb       fs
    add(0,   0,     0,   0,   0,   10'h3FF, 10'h3FF, 16'h0000, 1);
    add(1,   74,    1,   1,   0,   10'd0,   10'd0,   16'h0000, 0);
    add(1,   75,    1,   1,   1,   10'd1,   10'd0,   16'hFFFF, 0);
    add(1,   81,    1,   1,   1,   10'd7,   10'd0,   16'hFFFF, 0);
    add(1,   82,    1,   1,   1,   10'h3FF, 10'h3FF, 16'hFFFF, 0);
    add(1,   83,    1,   1,   0,   10'h3FF, 10'h3FF, 16'h0000, 0);
    add(0,   95,    0,   0,   0,   10'h3FF, 10'h3FF, 16'h0000, 0);
    add(0,   96,    1,   0,   0,   10'h3FF, 10'h3FF, 16'h0000, 0);
    add(1,   125,   1,   1,   0,   10'h3FF, 10'h3FF, 16'h0000, 0);
    add(1,   152,   1,   1,   0,   10'h3FF, 10'h3FF, 16'h0000, 0);
    add(1,   153,   0,   0,   0,   10'h3FF, 10'h3FF, 16'h0000, 1);
    add(1,   157,   1,   0,   0,   10'h3FF, 10'h3FF, 16'h0000, 0);
    add(0,   799,   1,   0,   0,   10'h3FF, 10'h3FF, 16'h0000, 0);
    add(0,   800,   0,   0,   0,   10'h3FF, 10'h3FF, 16'h0000, 0);
    add(0,   1600,  0,   1,   0,   10'h3FF, 10'h3FF, 16'h0000, 0);
    add(0,   1696,  1,   1,   0,   10'h3FF, 10'h3FF, 16'h0000, 0);
    add(0,   27343, 1,   1,   0,   10'h3FF, 10'h3FF, 16'h0000, 0);
    add(0,   28142, 1,   1,   0,   10'h3FF, 10'h3FF, 16'h0000, 0);
    add(0,   28143, 1,   1,   0,   10'd0,   10'd0,   16'h0000, 0);
    add(0,   28144, 1,   1,   1,   10'd1,   10'd0,   16'h0000, 0);
    add(0,   28400, 1,   1,   1,   10'd257, 10'd0,   16'h0100, 0);
    add(0,   28782, 1,   1,   1,   10'd639, 10'd0,   16'h027E, 0);
    add(0,   28783, 1,   1,   1,   10'h3FF, 10'h3FF, 16'h027F, 0);
    add(0,   28784, 1,   1,   0,   10'h3FF, 10'h3FF, 16'h0000, 0);

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (10) @(negedge vga_clk);
    chk_a("rst", 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b1);
    chk("rst_b.frame_start", fs_b, 1'b1);
    @(posedge vga_clk);
    #1;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    foreach (vecs[i]) begin
      wait_n(1'b0, vecs[i].n);
      if (vecs[i].sel) begin
        chk($sformatf("v%0d.hsync", i), hs_b, vecs[i].hs);
        chk($sformatf("v%0d.vsync", i), vs_b, vecs[i].vs);
        chk($sformatf("v%0d.rgb_valid", i), val_b, vecs[i].val);
        chk($sformatf("v%0d.pix_x", i), px_b, vecs[i].px);
        chk($sformatf("v%0d.pix_y", i), py_b, vecs[i].py);
        chk($sformatf("v%0d.rgb", i), rgb_b, vecs[i].rgb);
        chk($sformatf("v%0d.frame_start", i), fs_b, vecs[i].fs);
      end else begin
        chk_a($sformatf("v%0d", i), vecs[i].hs, vecs[i].vs, vecs[i].val,
              vecs[i].px, vecs[i].py, vecs[i].rgb, vecs[i].fs);
      end
    end

    wait_n(1'b0, 28800);
    chk("a.hsync_low_line0", hs_low_a0, 96);
    chk("a.hsync_low_35lines", hs_low_a, 96 * 35);
    chk("a.vsync_low_clks", vs_low_a, 1600);
    chk("a.rgb_blank_nonzero", rgb_nz_a, 0);
    chk("a.valid_line35", valid_a35, 640);
    chk("a.frame_start_extra", fs_extra_a, 0);
    chk("b.hsync_low_frame", hs_low_b, 4 * 9);
    chk("b.vsync_low_frame", vs_low_b, 2 * 17);
    chk("b.rgb_ffff_frame", ff_b, 8 * 3);
    chk("b.valid_frame", valid_b, 8 * 3);
    chk("b.frame_start_count", nfs_b, 4);
    chk("b.frame_start_first", fs_pos_b[0], 0);
    for (int k = 1; k < 4; k++)
      chk($sformatf("b.frame_start_gap%0d", k), fs_pos_b[k] - fs_pos_b[k-1], 153);

    // Asynchronous reset mid-line (cnt_h=400, cnt_v=36), between clock edges
    wait_n(1'b1, 36 * 800 + 400);
    chk("a.pre_rst.rgb_valid", val_a, 1'b1);
    #2;
    rst_a_n = 1'b0;
    #1;
    chk_a("arst", 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b1);
    repeat (3) @(posedge vga_clk);
    #1;
    rst_a_n = 1'b1;
    wait_n(1'b1, 0);
    chk_a("rel0", 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b1);
    wait_n(1'b1, 96);
    chk_a("rel96", 1'b1, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0);
    wait_n(1'b1, 800);
    chk_a("rel800", 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0);
    wait_n(1'b1, 1600);
    chk_a("rel1600", 1'b0, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
